// File: rtl/fpmult_ctrl_pkg.sv
// Shared definitions for the FP8 multiplier issue controller.
// Holds the FP8 field widths, the controller state encoding and the
// per-stage tag carried alongside each in-flight multiply.
package fpmult_ctrl_pkg;

   localparam int EXP_W = 3;
   localparam int MAN_W = 4;
   localparam int EXC_W = 5;
   localparam int FP_W  = 1 + EXP_W + MAN_W;

   // Wide enough for the largest supported requester count (8)
   localparam int ID_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/fpmult_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   en          - arbitration allowed this cycle (no grant when low)
//   req         - per-requester request vector
//   ptr         - index to start the search from (searches upward, wraps)
//   grant       - one-hot grant, zero when nothing is granted
//   grant_idx   - binary index of the granted requester
//   grant_valid - a grant was made
//   next_ptr    - grant_idx + 1 modulo NREQ, meaningful when grant_valid
module fpmult_rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic             en,
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic [PTR_W-1:0] next_ptr
);

   logic [PTR_W-1:0] idx;

   // Walk the requesters starting at ptr; the first active one wins.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NREQ);
         if (en && !grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
      // Explicit wrap so non-power-of-two requester counts stay in range
      next_ptr = (int'(grant_idx) == NREQ - 1) ? '0 : PTR_W'(int'(grant_idx) + 1);
   end

endmodule

// File: rtl/fpmult_issue_ctrl.sv
// Issue controller sharing one pipelined FP8 multiplier between NREQ
// requesters. Grants round-robin, issues at most one operand pair per cycle,
// tracks in-flight operations with a LAT-deep tag pipeline and steers each
// returning result/exception vector to the requester that issued it.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   enable                 - issue permission; low lets the pipeline drain
//   req_valid/req_a/req_b  - per-requester request and packed 8-bit operands
//   req_ready              - one-hot grant (handshake = valid & ready)
//   mul_valid/mul_a/mul_b  - issue strobe and operands to the datapath
//   mul_result/mul_exc     - datapath output, valid LAT cycles after issue
//   rsp_valid/rsp_result/rsp_exc - one-hot single-cycle completion
//   idle, inflight, done_cnt     - status
module fpmult_issue_ctrl
   import fpmult_ctrl_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int LAT  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*FP_W-1:0]     req_a,
   input  logic [NREQ*FP_W-1:0]     req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic                     mul_valid,
   output logic [FP_W-1:0]          mul_a,
   output logic [FP_W-1:0]          mul_b,
   input  logic [FP_W-1:0]          mul_result,
   input  logic [EXC_W-1:0]         mul_exc,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [FP_W-1:0]          rsp_result,
   output logic [EXC_W-1:0]         rsp_exc,
   output logic                     idle,
   output logic [$clog2(LAT+1)-1:0] inflight,
   output logic [15:0]              done_cnt
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(LAT + 1);

   ctrl_state_t      state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   tag_t             tag_q [LAT];
   tag_t             tag_d [LAT];
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [FP_W-1:0]  rsp_result_q, rsp_result_d;
   logic [EXC_W-1:0] rsp_exc_q, rsp_exc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [15:0]      done_cnt_q, done_cnt_d;

   logic             issue_en;
   logic [NREQ-1:0]  grant;
   logic [PTR_W-1:0] grant_idx;
   logic             handshake;
   logic [PTR_W-1:0] next_ptr;
   logic             complete;

   // Issue is gated by the live enable too, so dropping enable blocks
   // issue in that same cycle even though the state is still RUN.
   assign issue_en = (state_q == RUN) && enable;

   fpmult_rr_arbiter #(
      .NREQ (NREQ),
      .PTR_W(PTR_W)
   ) u_arb (
      .en         (issue_en),
      .req        (req_valid),
      .ptr        (rr_ptr_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_valid(handshake),
      .next_ptr   (next_ptr)
   );

   // The last tag stage lines up with mul_result being valid.
   assign complete = tag_q[LAT-1].valid;

   // Operand mux: zeros unless a handshake is happening this cycle.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            mul_a = req_a[i*FP_W +: FP_W];
            mul_b = req_b[i*FP_W +: FP_W];
         end
      end
   end

   assign req_ready = grant;
   assign mul_valid = handshake;

   // Next-state logic for the FSM, pointer, tag pipeline, response
   // registers and counters.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = (inflight_q != '0) ? DRAIN : IDLE;
         DRAIN: begin
            if (enable) state_d = RUN;
            else if (inflight_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      rr_ptr_d = handshake ? next_ptr : rr_ptr_q;

      tag_d[0].valid = handshake;
      tag_d[0].id    = ID_W'(grant_idx);
      for (int i = 1; i < LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      for (int i = 0; i < NREQ; i++) begin
         rsp_valid_d[i] = complete && (tag_q[LAT-1].id == ID_W'(i));
      end
      // Payload only captured for real completions so it holds otherwise
      rsp_result_d = complete ? mul_result : rsp_result_q;
      rsp_exc_d    = complete ? mul_exc    : rsp_exc_q;

      inflight_d = inflight_q;
      if (handshake && !complete) begin
         inflight_d = inflight_q + CNT_W'(1);
      end else if (!handshake && complete) begin
         inflight_d = inflight_q - CNT_W'(1);
      end

      done_cnt_d = done_cnt_q;
      if (complete && (done_cnt_q != 16'hFFFF)) begin
         done_cnt_d = done_cnt_q + 16'd1;
      end
   end

   // Single register block; reset clears the tag pipeline so results
   // still in the datapath at reset time never produce a response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= '0;
         end
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         rsp_exc_q    <= '0;
         inflight_q   <= '0;
         done_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         tag_q        <= tag_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_exc_q    <= rsp_exc_d;
         inflight_q   <= inflight_d;
         done_cnt_q   <= done_cnt_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_exc    = rsp_exc_q;
   assign idle       = (state_q == IDLE);
   assign inflight   = inflight_q;
   assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_fpmult_issue_ctrl.sv
// Directed testbench for fpmult_issue_ctrl with NREQ=2, LAT=3.
// A small FP8 multiplier model with LAT cycles of delay stands in for the
// datapath; empty pipeline slots output a junk pattern.
module tb_fpmult_issue_ctrl;

   localparam int NREQ = 2;
   localparam int LAT  = 3;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [1:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [1:0]  req_ready;
   logic        mul_valid;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [7:0]  mul_result;
   logic [4:0]  mul_exc;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_result;
   logic [4:0]  rsp_exc;
   logic        idle;
   logic [1:0]  inflight;
   logic [15:0] done_cnt;

   int errors = 0;
   int checks = 0;

   fpmult_issue_ctrl #(
      .NREQ(NREQ),
      .LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .mul_valid (mul_valid),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_result(mul_result),
      .mul_exc   (mul_exc),
      .rsp_valid (rsp_valid),
      .rsp_result(rsp_result),
      .rsp_exc   (rsp_exc),
      .idle      (idle),
      .inflight  (inflight),
      .done_cnt  (done_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FP8 (1/3/4, bias 3) multiply with truncation; zero operand flags 11000.
   function automatic logic [12:0] dp_model(input logic [7:0] a, input logic [7:0] b);
      logic       s;
      int         e;
      int         p;
      logic [3:0] m;
      s = a[7] ^ b[7];
      if (a[6:0] == 7'd0 || b[6:0] == 7'd0) begin
         return {s, 7'd0, 5'b11000};
      end
      p = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
      e = int'(a[6:4]) + int'(b[6:4]) - 3;
      if (p >= 512) begin
         m = p[8:5];
         e = e + 1;
      end else begin
         m = p[7:4];
      end
      if (e > 7) return {s, 7'h70, 5'b00100};
      if (e < 1) return {s, 7'h00, 5'b00010};
      return {s, 3'(e), m, 5'b00000};
   endfunction

   // Datapath stand-in: LAT register stages, junk 0xEF/0x1F when no issue.
   logic [12:0] dp_pipe [LAT];
   always @(posedge clk) begin
      dp_pipe[0] <= mul_valid ? dp_model(mul_a, mul_b) : 13'h1DFF;
      for (int i = 1; i < LAT; i++) begin
         dp_pipe[i] <= dp_pipe[i-1];
      end
   end
   assign mul_result = dp_pipe[LAT-1][12:5];
   assign mul_exc    = dp_pipe[LAT-1][4:0];

   // Hard stop in case anything stalls the sequence
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive the requester inputs for the current cycle
   task automatic applyStimulus(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                                input logic [7:0] a1, input logic [7:0] b1);
      req_valid = v;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
   endtask

   // Advance to just after the next rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst    = 1'b1;
      enable = 1'b0;
      applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst    = 1'b1;
      enable = 1'b1;
      applyStimulus(2'b11, 8'h30, 8'h40, 8'h38, 8'h40);
      tick;
      tick;
      #2;
      checks++;
      if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b want 1", idle); end
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready); end
      checks++;
      if (mul_valid !== 1'b0 || mul_a !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_mul: valid=%b a=%h want 0/00", mul_valid, mul_a);
      end
      checks++;
      if (rsp_valid !== 2'b00 || rsp_result !== 8'h00 || rsp_exc !== 5'h00) begin
         errors++; $display("[TB] FAIL reset_rsp: v=%b r=%h e=%b want 00/00/00000", rsp_valid, rsp_result, rsp_exc);
      end
      checks++;
      if (inflight !== 2'd0 || done_cnt !== 16'd0) begin
         errors++; $display("[TB] FAIL reset_counters: inflight=%0d done=%0d want 0/0", inflight, done_cnt);
      end
      rst    = 1'b0;
      enable = 1'b0;
      applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      tick;
   endtask

   task automatic test_single_op;
      do_reset;
      enable = 1'b1;
      tick;
      applyStimulus(2'b01, 8'h30, 8'h40, 8'h00, 8'h00);
      #2;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_grant: got %b want 01", req_ready); end
      checks++;
      if (mul_valid !== 1'b1 || mul_a !== 8'h30 || mul_b !== 8'h40) begin
         errors++; $display("[TB] FAIL single_issue: v=%b a=%h b=%h want 1/30/40", mul_valid, mul_a, mul_b);
      end
      tick;
      applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      #2;
      checks++;
      if (inflight !== 2'd1) begin errors++; $display("[TB] FAIL single_inflight: got %0d want 1", inflight); end
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL single_early_rsp: cycle+%0d got %b want 00", k, rsp_valid); end
         tick;
         #2;
      end
      checks++;
      if (rsp_valid !== 2'b01 || rsp_result !== 8'h40 || rsp_exc !== 5'h00) begin
         errors++; $display("[TB] FAIL single_rsp: v=%b r=%h e=%b want 01/40/00000", rsp_valid, rsp_result, rsp_exc);
      end
      checks++;
      if (done_cnt !== 16'd1 || inflight !== 2'd0) begin
         errors++; $display("[TB] FAIL single_counters: done=%0d inflight=%0d want 1/0", done_cnt, inflight);
      end
      tick;
      #2;
      checks++;
      if (rsp_valid !== 2'b00 || rsp_result !== 8'h40) begin
         errors++; $display("[TB] FAIL single_hold: v=%b r=%h want 00/40", rsp_valid, rsp_result);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_v;
      logic [7:0] exp_r;
      do_reset;
      enable = 1'b1;
      tick;
      for (int n = 0; n < 12; n++) begin
         if (n < 6) applyStimulus(2'b11, 8'h30, 8'h40, 8'h38, 8'h40);
         else       applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
         #2;
         if (n < 6) begin
            exp_v = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (n % 2 == 0) ? 8'h30 : 8'h38;
            checks++;
            if (req_ready !== exp_v || mul_a !== exp_r) begin
               errors++; $display("[TB] FAIL rr_grant: n=%0d ready=%b a=%h want %b/%h", n, req_ready, mul_a, exp_v, exp_r);
            end
         end
         if (n >= 4 && n < 10) begin
            exp_v = ((n - 4) % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = ((n - 4) % 2 == 0) ? 8'h40 : 8'h48;
         end else begin
            exp_v = 2'b00;
            exp_r = rsp_result;
         end
         checks++;
         if (rsp_valid !== exp_v || (exp_v != 2'b00 && rsp_result !== exp_r)) begin
            errors++; $display("[TB] FAIL rr_rsp: n=%0d v=%b r=%h want %b/%h", n, rsp_valid, rsp_result, exp_v, exp_r);
         end
         tick;
      end
   endtask

   task automatic test_exception;
      do_reset;
      enable = 1'b1;
      tick;
      applyStimulus(2'b10, 8'h00, 8'h00, 8'h00, 8'h45);
      #2;
      checks++;
      if (req_ready !== 2'b10 || mul_b !== 8'h45) begin
         errors++; $display("[TB] FAIL exc_grant: ready=%b b=%h want 10/45", req_ready, mul_b);
      end
      tick;
      applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      tick;
      tick;
      tick;
      #2;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_exc !== 5'b11000 || rsp_result !== 8'h00) begin
         errors++; $display("[TB] FAIL exc_rsp: v=%b e=%b r=%h want 10/11000/00", rsp_valid, rsp_exc, rsp_result);
      end
   endtask

   task automatic test_drain;
      int rsp_seen;
      rsp_seen = 0;
      do_reset;
      enable = 1'b1;
      tick;
      for (int n = 0; n < 3; n++) begin
         applyStimulus(2'b01, 8'h30, 8'h40, 8'h00, 8'h00);
         tick;
      end
      // Requester keeps asking while enable falls
      enable = 1'b0;
      #2;
      checks++;
      if (req_ready !== 2'b00 || mul_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL drain_fall_issue: ready=%b mv=%b want 00/0", req_ready, mul_valid);
      end
      checks++;
      if (inflight !== 2'd3) begin errors++; $display("[TB] FAIL drain_inflight3: got %0d want 3", inflight); end
      tick;
      for (int n = 4; n <= 8; n++) begin
         #2;
         if (rsp_valid == 2'b01) rsp_seen++;
         if (n == 4) begin
            checks++;
            if (idle !== 1'b0 || req_ready !== 2'b00) begin
               errors++; $display("[TB] FAIL drain_state: idle=%b ready=%b want 0/00", idle, req_ready);
            end
         end
         if (n == 6) begin
            checks++;
            if (inflight !== 2'd0 || idle !== 1'b0) begin
               errors++; $display("[TB] FAIL drain_empty: inflight=%0d idle=%b want 0/0", inflight, idle);
            end
         end
         if (n == 7) begin
            checks++;
            if (idle !== 1'b1) begin errors++; $display("[TB] FAIL drain_idle: got %b want 1", idle); end
         end
         tick;
      end
      checks++;
      if (rsp_seen != 3) begin errors++; $display("[TB] FAIL drain_rsp_count: got %0d want 3", rsp_seen); end
   endtask

   task automatic test_reset_midflight;
      do_reset;
      enable = 1'b1;
      tick;
      // Two grants to requester 0 leave the pointer at 1
      applyStimulus(2'b01, 8'h30, 8'h40, 8'h00, 8'h00);
      tick;
      tick;
      applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      enable = 1'b0;
      rst    = 1'b1;
      tick;
      rst = 1'b0;
      #2;
      checks++;
      if (inflight !== 2'd0 || idle !== 1'b1 || done_cnt !== 16'd0) begin
         errors++; $display("[TB] FAIL midrst_state: inflight=%0d idle=%b done=%0d want 0/1/0", inflight, idle, done_cnt);
      end
      checks++;
      if (rsp_result !== 8'h00 || rsp_exc !== 5'h00 || req_ready !== 2'b00 || mul_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_outputs: r=%h e=%b ready=%b mv=%b want 00/00000/00/0",
                            rsp_result, rsp_exc, req_ready, mul_valid);
      end
      for (int n = 0; n < 6; n++) begin
         checks++;
         if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL midrst_no_rsp: n=%0d got %b want 00", n, rsp_valid); end
         tick;
         #2;
      end
      enable = 1'b1;
      tick;
      applyStimulus(2'b11, 8'h30, 8'h40, 8'h38, 8'h40);
      #2;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL midrst_ptr: first grant %b want 01", req_ready); end
      tick;
      applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_full_pipeline;
      int rsp_seen;
      logic [1:0] exp_inf;
      rsp_seen = 0;
      do_reset;
      enable = 1'b1;
      tick;
      for (int k = 0; k < 28; k++) begin
         if (k < 20) applyStimulus(2'b01, 8'h30, 8'h40, 8'h00, 8'h00);
         else        applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
         #2;
         if (k < 20) begin
            exp_inf = (k < 3) ? 2'(k) : 2'd3;
            checks++;
            if (inflight !== exp_inf) begin
               errors++; $display("[TB] FAIL full_inflight: k=%0d got %0d want %0d", k, inflight, exp_inf);
            end
         end
         if (rsp_valid == 2'b01) begin
            rsp_seen++;
            checks++;
            if (rsp_result !== 8'h40) begin
               errors++; $display("[TB] FAIL full_result: k=%0d got %h want 40", k, rsp_result);
            end
         end
         if (k == 23) begin
            checks++;
            if (done_cnt !== 16'd20) begin errors++; $display("[TB] FAIL full_done_cnt: got %0d want 20", done_cnt); end
         end
         tick;
      end
      checks++;
      if (rsp_seen != 20) begin errors++; $display("[TB] FAIL full_rsp_count: got %0d want 20", rsp_seen); end
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b0;
      applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      test_reset;
      test_single_op;
      test_back_to_back;
      test_exception;
      test_drain;
      test_reset_midflight;
      test_full_pipeline;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpmult_issue_ctrl.md
# fpmult_issue_ctrl

Issue controller that shares one pipelined 8-bit floating-point multiplier datapath (1 sign, 3 exponent, 4 mantissa bits) between `NREQ` requesters. It sits between the requester ports and the multiplier front end, which is the prep, exception and zero-detect stage. It picks requesters round-robin, issues at most one operand pair per cycle, and tracks in-flight operations with a tag pipeline. Each result and its exception flags are routed back to the requester that issued the operation.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `LAT`, 3: fixed datapath latency, issue cycle to `mul_result` valid (1..8).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: issue permission; low stops new issues and lets the pipeline drain.
- `req_valid` in NREQ: per-requester operation request.
- `req_a` in NREQ×8: operand A per requester.
- `req_b` in NREQ×8: operand B per requester.
- `req_ready` out NREQ: one-hot grant; handshake when `req_valid[i] & req_ready[i]`.
- `mul_valid` out 1: issue strobe to datapath.
- `mul_a` out 8: operand A to datapath.
- `mul_b` out 8: operand B to datapath.
- `mul_result` in 8: datapath product, valid exactly `LAT` cycles after issue.
- `mul_exc` in 5: datapath exception vector, same timing as `mul_result`.
- `rsp_valid` out NREQ: one-hot, single-cycle completion.
- `rsp_result` out 8: product for the flagged requester.
- `rsp_exc` out 5: exception vector for the flagged requester.
- `idle` out 1: high in IDLE state.
- `inflight` out clog2(LAT+1): count of issued, not-yet-completed operations.
- `done_cnt` out 16: completed operations, saturating at 0xFFFF.

## Operation
- FSM states:
  - IDLE: `enable`=0 and pipeline empty.
  - RUN: `enable`=1.
  - DRAIN: `enable`=0 and pipeline non-empty.
- FSM transitions:
  - IDLE→RUN when `enable`=1.
  - RUN→DRAIN when `enable`=0 and `inflight`≠0.
  - RUN→IDLE when `enable`=0 and `inflight`=0.
  - DRAIN→RUN when `enable`=1.
  - DRAIN→IDLE when `inflight` becomes 0.
- Issue happens only in RUN. `req_ready` is all-zero in IDLE and DRAIN.
- Arbitration:
  - The grant goes to the first `req_valid` at or after pointer `rr_ptr`, searching upward and wrapping.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and state.
  - At most one bit of `req_ready` is set, and only when its `req_valid` is high.
  - On a handshake, `rr_ptr` ← grant index + 1 mod NREQ. With no handshake, `rr_ptr` holds.
- In the handshake cycle, `mul_valid`=1 and `mul_a`/`mul_b` = the granted operands, combinationally. Otherwise `mul_valid`=0 and `mul_a`/`mul_b`=0.
- Tag pipeline: `LAT` stages of {valid, id}. Stage 0 loads {handshake, grant index}.
- At stage `LAT`-1, in the cycle where `mul_result` is valid, the controller registers:
  - `rsp_valid` ← onehot(id) if the stage is valid, else 0.
  - `rsp_result` ← `mul_result`.
  - `rsp_exc` ← `mul_exc`.
- `rsp_result`/`rsp_exc` hold their last value when `rsp_valid`=0. Operands and results are passed through unmodified; no FP arithmetic happens in this block.
- Responses have no backpressure; requesters must accept `rsp_valid` in the cycle it is asserted.
- `inflight` counter:
  - Increments on issue and decrements on completion.
  - Issue and completion in the same cycle leave it unchanged.
  - It never exceeds `LAT`.
- `done_cnt` increments on each completion and saturates at 0xFFFF.

## Timing
- A handshake in cycle t gives `rsp_valid[i]`=1 in cycle t+LAT+1, for exactly one cycle.
- Throughput is one operation per cycle, so back-to-back grants are allowed.
- `enable` falling in cycle t: no issue in cycle t. Operations already in flight complete normally.
- Reset values:
  - state = IDLE, `rr_ptr`=0.
  - Tag pipeline all invalid.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_exc`=0.
  - `inflight`=0, `done_cnt`=0, `idle`=1, `req_ready`=0, `mul_valid`=0.
- Reset mid-operation: in-flight results are dropped and no `rsp_valid` is produced for them. Responses arriving later from the datapath are ignored.

## Structure
- Package `fpmult_ctrl_pkg` holds:
  - FP8 field widths (`EXP_W`=3, `MAN_W`=4, `EXC_W`=5).
  - State enum `ctrl_state_t` {IDLE, RUN, DRAIN}.
  - Struct `tag_t` {valid, id}.
- Sub-module `fpmult_rr_arbiter`: combinational round-robin grant from request vector and pointer, plus next-pointer logic.

## Test plan
- Single op, LAT=3: issue requester 0 with a=0x30, b=0x40 in cycle 5. Required: `rsp_valid`=01 in cycle 9 only, `rsp_result`=0x40 (bench datapath model), `done_cnt`=1.
- Fairness: both requesters hold valid for 6 cycles. Required: grants alternate 0,1,0,1,0,1; responses alternate in the same order, 1 per cycle.
- Exception pass-through: a=0x00, b=0x45, model returns `mul_exc`=5'b11000. Required: `rsp_exc`=5'b11000 to the issuing requester.
- Drain: issue 3 back-to-back ops, then drop `enable`. Required:
  - State is DRAIN with `req_ready`=0.
  - 3 responses arrive.
  - `idle`=1 the cycle after `inflight` reaches 0.
- Reset mid-flight: assert `rst` with 2 ops in flight. Required: no `rsp_valid` afterwards, `inflight`=0, `rr_ptr`=0, all outputs at reset values.
- Full pipeline: continuous valid on one requester for 20 cycles. Required: `inflight` steady at 3, `done_cnt`=20 after the final response.
